// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control sequencer: one Moore FSM shares the memory port and ALU across
// 3-5 cycles per instruction, stalls on mem_ready, parks in HALT on illegal encodings.
//
// state    | meaning
// ---------+----------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 on ready
// DECODE   | branch target into ALUOut, dispatch on opcode
// MEMADR   | effective address for lw/sw
// MEMRD    | data read at ALUOut, wait for ready
// MEMWB    | MDR -> rt
// MEMWR    | data write at ALUOut, wait for ready
// EXEC     | R-type ALU operation
// ALUWB    | ALUOut -> rd
// BRANCH   | beq compare, PC <= ALUOut if zero
// ADDIEX   | rs + imm
// ADDIWB   | ALUOut -> rt
// JUMP     | PC <= jump target
// JAL      | PC <= jump target, r31 <= PC
// JR       | PC <= rs
// HALT     | illegal instruction, only reset leaves
module multicycle_control_unit #(
  parameter int CNT_W       = 32,
  parameter bit ENABLE_LINK = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC, S_ALUWB,
    S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_JAL, S_JR, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             funct_alu_ok;

  assign funct_alu_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                        (funct == FN_OR)  || (funct == FN_SLT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_RTYPE && funct == FN_JR)
          state_d = ENABLE_LINK ? S_JR : S_HALT;
        else if (opcode == OP_RTYPE && funct_alu_ok)
          state_d = S_EXEC;
        else if (opcode == OP_LW || opcode == OP_SW)
          state_d = S_MEMADR;
        else if (opcode == OP_BEQ)
          state_d = S_BRANCH;
        else if (opcode == OP_ADDI)
          state_d = S_ADDIEX;
        else if (opcode == OP_J)
          state_d = S_JUMP;
        else if (opcode == OP_JAL)
          state_d = ENABLE_LINK ? S_JAL : S_HALT;
        else
          state_d = S_HALT;
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP, S_JAL, S_JR:
                state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // Every return to FETCH retires exactly one instruction; HALT never returns.
  always_comb begin
    count_d = count_q;
    if (state_d == S_FETCH && state_q != S_FETCH)
      count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_ctrl      = ALU_AND;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    halted        = 1'b0;
    // Reset blanks every strobe so an interrupted instruction leaves no partial write.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_ctrl  = ALU_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          alu_ctrl  = ALU_ADD;
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_ctrl  = ALU_ADD;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          case (funct)
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: alu_ctrl = ALU_ADD;
          endcase
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_ctrl      = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        S_JAL: begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        S_JR: begin
          pc_write = 1'b1;
          pc_src   = 2'b11;
        end
        S_HALT:  halted = 1'b1;
        default: halted = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: the driver expands each instruction into its expected per-cycle control
// words; a negedge monitor pops them and compares against two DUTs (link enabled/disabled).
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       halted;
  } ctrl_t;

  typedef struct packed {
    ctrl_t      c1;
    logic [3:0] n1;
    ctrl_t      c2;
    logic [3:0] n2;
    logic       ign_h;
  } exp_t;

  localparam ctrl_t HALTW = ctrl_t'(21'd1);
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;

  always #5 clk = ~clk;

  logic       d1_mem_read, d1_mem_write, d1_i_or_d, d1_ir_write, d1_pc_write, d1_pc_write_cond;
  logic [1:0] d1_pc_src, d1_alu_src_b, d1_reg_dst, d1_mem_to_reg;
  logic       d1_alu_src_a, d1_reg_write, d1_halted;
  logic [3:0] d1_alu_ctrl, d1_count;
  logic       d2_mem_read, d2_mem_write, d2_i_or_d, d2_ir_write, d2_pc_write, d2_pc_write_cond;
  logic [1:0] d2_pc_src, d2_alu_src_b, d2_reg_dst, d2_mem_to_reg;
  logic       d2_alu_src_a, d2_reg_write, d2_halted;
  logic [3:0] d2_alu_ctrl, d2_count;

  multicycle_control_unit #(.CNT_W(4), .ENABLE_LINK(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_read(d1_mem_read), .mem_write(d1_mem_write), .i_or_d(d1_i_or_d),
    .ir_write(d1_ir_write), .pc_write(d1_pc_write), .pc_write_cond(d1_pc_write_cond),
    .pc_src(d1_pc_src), .alu_src_a(d1_alu_src_a), .alu_src_b(d1_alu_src_b),
    .alu_ctrl(d1_alu_ctrl), .reg_write(d1_reg_write), .reg_dst(d1_reg_dst),
    .mem_to_reg(d1_mem_to_reg), .halted(d1_halted), .instr_count(d1_count)
  );

  multicycle_control_unit #(.CNT_W(4), .ENABLE_LINK(1'b0)) dut_nolink (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_read(d2_mem_read), .mem_write(d2_mem_write), .i_or_d(d2_i_or_d),
    .ir_write(d2_ir_write), .pc_write(d2_pc_write), .pc_write_cond(d2_pc_write_cond),
    .pc_src(d2_pc_src), .alu_src_a(d2_alu_src_a), .alu_src_b(d2_alu_src_b),
    .alu_ctrl(d2_alu_ctrl), .reg_write(d2_reg_write), .reg_dst(d2_reg_dst),
    .mem_to_reg(d2_mem_to_reg), .halted(d2_halted), .instr_count(d2_count)
  );

  ctrl_t act1, act2;
  assign act1 = ctrl_t'({d1_mem_read, d1_mem_write, d1_i_or_d, d1_ir_write, d1_pc_write,
                         d1_pc_write_cond, d1_pc_src, d1_alu_src_a, d1_alu_src_b, d1_alu_ctrl,
                         d1_reg_write, d1_reg_dst, d1_mem_to_reg, d1_halted});
  assign act2 = ctrl_t'({d2_mem_read, d2_mem_write, d2_i_or_d, d2_ir_write, d2_pc_write,
                         d2_pc_write_cond, d2_pc_src, d2_alu_src_a, d2_alu_src_b, d2_alu_ctrl,
                         d2_reg_write, d2_reg_dst, d2_mem_to_reg, d2_halted});

  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc_no = 0;

  // Reference model state: retired counts and halt flags for each DUT.
  logic [3:0] cnt1 = 4'd0, cnt2 = 4'd0;
  bit         halted1 = 1'b0, halted2 = 1'b0;

  ctrl_t bq[$];
  logic  bm[$];

  always @(negedge clk) begin : monitor
    exp_t  e;
    ctrl_t a1, a2, x1, x2;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      a1 = act1; a2 = act2; x1 = e.c1; x2 = e.c2;
      if (e.ign_h) begin
        a1.halted = 1'b0; a2.halted = 1'b0; x1.halted = 1'b0; x2.halted = 1'b0;
      end
      checks++;
      if (a1 !== x1) begin
        errors++;
        $display("FAIL ctrl_link1 cycle=%0d got=%06h expected=%06h", cyc_no, a1, x1);
      end
      checks++;
      if (d1_count !== e.n1) begin
        errors++;
        $display("FAIL count_link1 cycle=%0d got=%0d expected=%0d", cyc_no, d1_count, e.n1);
      end
      checks++;
      if (a2 !== x2) begin
        errors++;
        $display("FAIL ctrl_link0 cycle=%0d got=%06h expected=%06h", cyc_no, a2, x2);
      end
      checks++;
      if (d2_count !== e.n2) begin
        errors++;
        $display("FAIL count_link0 cycle=%0d got=%0d expected=%0d", cyc_no, d2_count, e.n2);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h2a:   return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic cyc(input logic r, input logic mr, input ctrl_t e1, input ctrl_t e2,
                     input logic ignh);
    rst       = r;
    mem_ready = mr;
    exp_q.push_back('{c1: e1, n1: cnt1, c2: e2, n2: cnt2, ign_h: ignh});
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic put(input ctrl_t c, input logic m);
    bq.push_back(c);
    bm.push_back(m);
  endtask

  // Expected control words and mem_ready pattern for one instruction, straight from the
  // instruction-class rules; hlt reports that it is an illegal encoding.
  task automatic build(input bit link, input logic [5:0] op, input logic [5:0] fn,
                       input int fw, input int mw, output bit hlt);
    ctrl_t c;
    bit    rt_ok;
    bq.delete();
    bm.delete();
    hlt   = 1'b0;
    rt_ok = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2a);
    c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_ctrl = A_ADD;
    for (int i = 0; i < fw; i++) put(c, 1'b0);
    c.ir_write = 1'b1; c.pc_write = 1'b1;
    put(c, 1'b1);
    c = '0; c.alu_src_b = 2'b11; c.alu_ctrl = A_ADD;
    put(c, rb());
    if (op == 6'h00 && fn == 6'h08 && link) begin
      c = '0; c.pc_write = 1'b1; c.pc_src = 2'b11; put(c, rb());
    end else if (op == 6'h00 && rt_ok) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_ctrl = alu_of(fn); put(c, rb());
      c = '0; c.reg_write = 1'b1; c.reg_dst = 2'b01; put(c, rb());
    end else if (op == 6'h23 || op == 6'h2b) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctrl = A_ADD; put(c, rb());
      c = '0; c.i_or_d = 1'b1;
      if (op == 6'h23) c.mem_read = 1'b1; else c.mem_write = 1'b1;
      for (int i = 0; i < mw; i++) put(c, 1'b0);
      put(c, 1'b1);
      if (op == 6'h23) begin
        c = '0; c.reg_write = 1'b1; c.mem_to_reg = 2'b01; put(c, rb());
      end
    end else if (op == 6'h04) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_ctrl = A_SUB; c.pc_write_cond = 1'b1; c.pc_src = 2'b01;
      put(c, rb());
    end else if (op == 6'h08) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctrl = A_ADD; put(c, rb());
      c = '0; c.reg_write = 1'b1; put(c, rb());
    end else if (op == 6'h02) begin
      c = '0; c.pc_write = 1'b1; c.pc_src = 2'b10; put(c, rb());
    end else if (op == 6'h03 && link) begin
      c = '0; c.pc_write = 1'b1; c.pc_src = 2'b10; c.reg_write = 1'b1;
      c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; put(c, rb());
    end else begin
      put(HALTW, rb());
      hlt = 1'b1;
    end
  endtask

  task automatic do_reset();
    cyc(1'b1, rb(), '0, '0, 1'b1);
    cnt1 = 4'd0; cnt2 = 4'd0;
    halted1 = 1'b0; halted2 = 1'b0;
  endtask

  // cut > 0: run only that many cycles, then assert reset in the following one.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input int fw,
                       input int mw, input int cut);
    ctrl_t s0[$];
    bit    h0, h1;
    int    n;
    ctrl_t e2;
    opcode = op;
    funct  = fn;
    build(1'b0, op, fn, fw, mw, h0);
    s0 = bq;
    build(1'b1, op, fn, fw, mw, h1);
    n = bq.size();
    if (cut > 0 && cut < n) n = cut;
    for (int i = 0; i < n; i++) begin
      e2 = (halted2 || i >= s0.size()) ? HALTW : s0[i];
      cyc(1'b0, bm[i], bq[i], e2, 1'b0);
    end
    if (cut > 0 && cut < bq.size()) begin
      do_reset();
    end else begin
      if (h1) halted1 = 1'b1; else cnt1++;
      if (!halted2) begin
        if (h0) halted2 = 1'b1; else cnt2++;
      end
    end
  endtask

  task automatic rand_instr();
    logic [5:0] op, fn;
    op = 6'h00;
    fn = 6'($urandom_range(0, 63));
    case ($urandom_range(0, 9))
      0: op = 6'h23;
      1: op = 6'h2b;
      2: op = 6'h04;
      3: op = 6'h08;
      4: op = 6'h02;
      5: op = 6'h03;
      6: fn = 6'h08;
      default: begin
        case ($urandom_range(0, 4))
          0: fn = 6'h20;
          1: fn = 6'h22;
          2: fn = 6'h24;
          3: fn = 6'h25;
          default: fn = 6'h2a;
        endcase
      end
    endcase
    issue(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin : driver
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    issue(6'h23, 6'h00, 0, 0, 0);
    issue(6'h00, 6'h2a, 0, 0, 0);
    issue(6'h00, 6'h22, 0, 0, 0);
    issue(6'h00, 6'h20, 1, 0, 0);
    issue(6'h00, 6'h24, 0, 0, 0);
    issue(6'h00, 6'h25, 2, 0, 0);
    issue(6'h2b, 6'h00, 3, 2, 0);
    issue(6'h08, 6'h00, 0, 0, 0);
    issue(6'h04, 6'h00, 0, 0, 0);
    issue(6'h03, 6'h00, 0, 0, 0);
    issue(6'h00, 6'h08, 1, 0, 0);
    for (int i = 0; i < 40; i++) rand_instr();
    do_reset();
    issue(6'h3f, 6'h00, 1, 0, 0);
    for (int i = 0; i < 100; i++) begin
      opcode = 6'($urandom_range(0, 63));
      cyc(1'b0, rb(), HALTW, HALTW, 1'b0);
    end
    do_reset();
    for (int i = 0; i < 16; i++) issue(6'h02, 6'($urandom_range(0, 63)), 0, 0, 0);
    issue(6'h23, 6'h00, 0, 2, 3);
    issue(6'h23, 6'h00, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 60; i++) rand_instr();
    cyc(1'b1, rb(), '0, '0, 1'b1);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
